seg_scan: RTL and testbench



---
 rtl/seg_scan_if.sv | 28 ++
 rtl/seg_scan.sv | 107 ++++++++++
 tb/tb_seg_scan.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Bus between the display client (master) and the seven-segment scanner (slave).
// wr_en and load_all are single-cycle strobes with no back-pressure. Each one is accepted on the edge where it is seen high.
interface seg_scan_if #(
    parameter int DIGITS = 8,
    parameter int SEG_W  = 7,
    parameter int AW     = $clog2(DIGITS)
) ();
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [SEG_W-1:0]        wr_data;
    logic                    load_all;
    logic [DIGITS*SEG_W-1:0] all_data;
    logic [DIGITS-1:0]       digit_en;
    logic [DIGITS-1:0]       blink_mask;
    logic [SEG_W-1:0]        seg_out;
    logic [DIGITS-1:0]       sel_out;
    logic                    frame_start;

    modport master (
        output wr_en, wr_addr, wr_data, load_all, all_data, digit_en, blink_mask,
        input  seg_out, sel_out, frame_start
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, load_all, all_data, digit_en, blink_mask,
        output seg_out, sel_out, frame_start
    );
endinterface

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner: a frame buffer, slot/digit/frame counters and registered pin outputs.
// Each slot starts with anti-ghosting blank cycles. Digits can be enabled or blinked one by one.
module seg_scan #(
    parameter int DIGITS         = 8,
    parameter int SEG_W          = 7,
    parameter int SCAN_DIV       = 1350,
    parameter int BLANK_CYCLES   = 2,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 0,
    parameter int AW             = $clog2(DIGITS)
) (
    input  logic     clk,
    input  logic     rst,
    seg_scan_if.slave bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0]     CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [AW-1:0]     IDX_LAST  = AW'(DIGITS - 1);
    localparam logic [FW-1:0]     FCNT_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [SEG_W-1:0]  SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [DIGITS-1:0] SEL_IDLE  = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

    logic              rst_q;
    logic              clr;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic              blink_off_q, blink_off_d;
    logic [SEG_W-1:0]  fb_q [DIGITS];
    logic [SEG_W-1:0]  fb_d [DIGITS];
    logic [SEG_W-1:0]  seg_q, seg_d, seg_lit;
    logic [DIGITS-1:0] sel_q, sel_d, sel_lit;
    logic              fs_q, fs_d;
    logic              idle;

    // Reset is held for one extra edge so that the scan starts at cnt=0 on the first edge after release.
    assign clr = rst | rst_q;

    always_comb begin
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        fcnt_d      = fcnt_q;
        blink_off_d = blink_off_q;
        if (cnt_q == CNT_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
                fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
                if (fcnt_q == FCNT_LAST) blink_off_d = ~blink_off_q;
            end
        end
    end

    // Bulk load wins over a single-entry write. Addresses with no matching digit fall through and are ignored.
    always_comb begin
        fb_d = fb_q;
        if (bus.load_all) begin
            for (int d = 0; d < DIGITS; d++) fb_d[d] = bus.all_data[(DIGITS-1-d)*SEG_W +: SEG_W];
        end else if (bus.wr_en) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (bus.wr_addr == AW'(d)) fb_d[d] = bus.wr_data;
            end
        end
    end

    always_comb begin
        idle    = (int'(cnt_q) < BLANK_CYCLES) || !bus.digit_en[idx_q];
        seg_lit = fb_q[idx_q];
        sel_lit = DIGITS'(1) << idx_q;
        if (blink_off_q && bus.blink_mask[idx_q]) seg_lit = '0;
        if (idle) begin
            seg_lit = '0;
            sel_lit = '0;
        end
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
        sel_d = (SEL_ACTIVE_LOW != 0) ? ~sel_lit : sel_lit;
        fs_d  = (cnt_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (clr) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            fcnt_q      <= '0;
            blink_off_q <= 1'b0;
            for (int d = 0; d < DIGITS; d++) fb_q[d] <= '0;
            seg_q       <= SEG_OFF;
            sel_q       <= SEL_IDLE;
            fs_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            fcnt_q      <= fcnt_d;
            blink_off_q <= blink_off_d;
            fb_q        <= fb_d;
            seg_q       <= seg_d;
            sel_q       <= sel_d;
            fs_q        <= fs_d;
        end
    end

    assign bus.seg_out     = seg_q;
    assign bus.sel_out     = sel_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: a position-based reference model scores every cycle.
// Literal checkpoints pin reset, scan order, write priority, blink, disable and mid-frame reset.
module tb_seg_scan;
    localparam int D     = 4;
    localparam int SW    = 7;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int BLINK = 2;
    localparam int OW    = SW + D + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_if #(.DIGITS(D), .SEG_W(SW)) bus ();

    seg_scan #(
        .DIGITS(D), .SEG_W(SW), .SCAN_DIV(DIV), .BLANK_CYCLES(BLANK),
        .BLINK_FRAMES(BLINK), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [OW-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int edge_n = -1;
    int pos = 0;
    bit rst_prev = 1'b1;
    logic [SW-1:0] mb [D];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t edge=%0d got=%h want=%h", name, $time, edge_n, act, exp);
        end
    endtask

    // Outputs for scan position p (cycles since the scan restarted), from the scan arithmetic alone.
    function automatic logic [OW-1:0] model_out(int p, logic [D-1:0] en, logic [D-1:0] mask);
        int cnt = p % DIV;
        int idx = (p / DIV) % D;
        int frame = p / (D * DIV);
        bit boff = ((frame / BLINK) % 2) == 1;
        logic [SW-1:0] seg = '0;
        logic [D-1:0] sel = '0;
        if (cnt >= BLANK && en[idx]) begin
            sel[idx] = 1'b1;
            if (!(boff && mask[idx])) seg = mb[idx];
        end
        return {~seg, sel, (p % (D * DIV)) == 0};
    endfunction

    always @(posedge clk) begin
        if (rst || rst_prev) begin
            exp_q.push_back({{SW{1'b1}}, {D{1'b0}}, 1'b0});
            pos = 0;
            for (int d = 0; d < D; d++) mb[d] = '0;
        end else begin
            exp_q.push_back(model_out(pos, bus.digit_en, bus.blink_mask));
            if (bus.load_all) begin
                for (int d = 0; d < D; d++) mb[d] = bus.all_data[(D-1-d)*SW +: SW];
            end else if (bus.wr_en) begin
                mb[bus.wr_addr] = bus.wr_data;
            end
            pos++;
        end
        rst_prev = rst;
        edge_n = rst ? -1 : edge_n + 1;
    end

    always @(negedge clk) begin
        logic [OW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seg", 32'(bus.seg_out), 32'(e[OW-1 -: SW]));
            check("sel", 32'(bus.sel_out), 32'(e[D:1]));
            check("fs", 32'(bus.frame_start), 32'(e[0]));
        end
    end

    task automatic to_edge(int e);
        for (int k = 0; k < 2000 && edge_n != e; k++) @(negedge clk);
        if (edge_n != e) check("to_edge_timeout", 32'(edge_n), 32'(e));
    endtask

    task automatic lit(string name, logic [SW-1:0] s, logic [D-1:0] sl, logic f);
        check({name, "_seg"}, 32'(bus.seg_out), 32'(s));
        check({name, "_sel"}, 32'(bus.sel_out), 32'(sl));
        check({name, "_fs"}, 32'(bus.frame_start), 32'(f));
    endtask

    initial begin
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.load_all   = 1'b0;
        bus.all_data   = '0;
        bus.digit_en   = 4'hF;
        bus.blink_mask = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        to_edge(0);  lit("rst_e0", 7'h7F, 4'b0000, 1'b0);
        to_edge(1);  lit("rst_e1", 7'h7F, 4'b0000, 1'b1);
        to_edge(2);  lit("rst_e2", 7'h7F, 4'b0000, 1'b0);
        bus.load_all = 1'b1;
        bus.all_data = {7'h06, 7'h5B, 7'h4F, 7'h66};
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 2'd1;
        bus.wr_data  = 7'h7F;
        to_edge(3);  lit("first_drive", 7'h7F, 4'b0001, 1'b0);
        bus.load_all = 1'b0;
        bus.wr_en    = 1'b0;
        to_edge(4);  lit("d0_on", 7'h79, 4'b0001, 1'b0);
        to_edge(8);  lit("d0_last", 7'h79, 4'b0001, 1'b0);
        to_edge(9);  lit("d1_blank", 7'h7F, 4'b0000, 1'b0);
        to_edge(11); lit("d1_prio", 7'h24, 4'b0010, 1'b0);
        to_edge(19); lit("d2_on", 7'h30, 4'b0100, 1'b0);
        to_edge(27); lit("d3_on", 7'h19, 4'b1000, 1'b0);
        to_edge(33); lit("frame2", 7'h7F, 4'b0000, 1'b1);

        to_edge(40);
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 2'd2;
        bus.wr_data    = 7'h3F;
        bus.blink_mask = 4'b0100;
        to_edge(41);
        bus.wr_en = 1'b0;
        to_edge(52);  lit("d2_write", 7'h40, 4'b0100, 1'b0);
        to_edge(83);  lit("blink_off", 7'h7F, 4'b0100, 1'b0);
        to_edge(85);  lit("blink_off2", 7'h7F, 4'b0100, 1'b0);
        to_edge(91);  lit("blink_other", 7'h19, 4'b1000, 1'b0);
        to_edge(147); lit("blink_on", 7'h40, 4'b0100, 1'b0);

        to_edge(160);
        bus.digit_en = 4'b1011;
        to_edge(179); lit("disabled", 7'h7F, 4'b0000, 1'b0);
        to_edge(193); lit("dis_period", 7'h7F, 4'b0000, 1'b1);

        to_edge(200);
        for (int k = 0; k < 420; k++) begin
            bus.wr_en    = ($urandom_range(0, 2) == 0);
            bus.wr_addr  = 2'($urandom_range(0, D - 1));
            bus.wr_data  = 7'($urandom);
            bus.load_all = ($urandom_range(0, 15) == 0);
            bus.all_data = 28'($urandom);
            if (k % 64 == 0) begin
                bus.digit_en   = 4'($urandom);
                bus.blink_mask = 4'($urandom);
            end
            @(negedge clk);
        end
        bus.wr_en      = 1'b0;
        bus.load_all   = 1'b0;
        bus.digit_en   = 4'hF;
        bus.blink_mask = 4'h0;

        to_edge(629);
        rst = 1'b1;
        @(negedge clk);
        lit("midrst", 7'h7F, 4'b0000, 1'b0);
        rst = 1'b0;
        to_edge(0);  lit("rel_e0", 7'h7F, 4'b0000, 1'b0);
        to_edge(1);  lit("rel_e1", 7'h7F, 4'b0000, 1'b1);
        to_edge(3);  lit("rel_d0", 7'h7F, 4'b0001, 1'b0);
        to_edge(4);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd0;
        bus.wr_data = 7'h06;
        to_edge(5);
        bus.wr_en = 1'b0;
        to_edge(6);  lit("live_write", 7'h79, 4'b0001, 1'b0);
        to_edge(40);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
